pixel_tagger: RTL and testbench

PIXEL_TAGGER -- requirements
Module: pixel_tagger

---
 rtl/pixel_tagger_if.sv | 28 ++
 rtl/pixel_tagger.sv | 149 ++++++++++++++
 tb/tb_pixel_tagger.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pixel_tagger_if.sv
// Pixel tagger stream interface: raw grayscale pixels in,
// coordinate-tagged pixels and frame status out.
interface pixel_tagger_if;
  logic        sof;
  logic        pix_valid;
  logic [11:0] pix;
  logic [34:0] data_out;
  logic        frame_done;
  logic        busy;

  modport master (
    output sof,
    output pix_valid,
    output pix,
    input  data_out,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  sof,
    input  pix_valid,
    input  pix,
    output data_out,
    output frame_done,
    output busy
  );
endinterface

// File: rtl/pixel_tagger.sv
// Tags each grayscale pixel with its (x, y) position in the frame.
// Optional TAGGER_ERR_CNT_EN adds err_cnt / short_frame outputs.
module pixel_tagger #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 960
) (
  input logic           clk,
  input logic           rst_n,
  pixel_tagger_if.slave bus
`ifdef TAGGER_ERR_CNT_EN
  ,
  output logic [7:0]    err_cnt,
  output logic          short_frame
`endif
);

  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [10:0] cur_x, cur_y;
  logic        accept;
  logic [34:0] data_q;
  logic        fd_q;
  logic        busy_q;

  // Next state, next counters, and whether this pixel is tagged.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cur_x   = bus.sof ? 11'd0 : x_q;
    cur_y   = bus.sof ? 11'd0 : y_q;
    accept  = bus.pix_valid &&
              (bus.sof || (state_q == ACTIVE));
    unique case (state_q)
      IDLE: begin
        if (bus.sof) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ACTIVE: begin
        if (bus.sof) begin
          x_d = '0;
          y_d = '0;
        end
      end
      DONE: begin
        state_d = bus.sof ? ACTIVE : IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
    if (accept) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          y_d     = '0;
          state_d = DONE;
        end else begin
          y_d = cur_y + 11'd1;
        end
      end else begin
        x_d = cur_x + 11'd1;
        y_d = cur_y;
      end
    end
  end

  // State and position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Tagged output; payload bits hold through idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= {1'b1, cur_y, cur_x, bus.pix};
    end else begin
      data_q[34] <= 1'b0;
    end
  end

  // frame_done follows the DONE cycle; busy mirrors ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      fd_q   <= (state_q == DONE);
      busy_q <= (state_d == ACTIVE);
    end
  end

  assign bus.data_out   = data_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;

`ifdef TAGGER_ERR_CNT_EN
  logic [7:0] err_q;
  logic       short_q;
  logic       err_hit;

  assign err_hit = (state_q == ACTIVE) && bus.sof &&
                   ((x_q != '0) || (y_q != '0));

  // Count aborted frames, saturating; flag is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q   <= '0;
      short_q <= 1'b0;
    end else if (err_hit) begin
      short_q <= 1'b1;
      if (err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign err_cnt     = err_q;
  assign short_frame = short_q;
`endif

endmodule

// File: tb/tb_pixel_tagger.sv
// Directed scoreboard bench for pixel_tagger (IMG_W=4, IMG_H=2).
// Optional error counter checked when TAGGER_ERR_CNT_EN is set.
module tb_pixel_tagger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [34:0] sb[$];
  logic [33:0] held = '0;

  pixel_tagger_if bus ();

`ifdef TAGGER_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic       short_frame;
`endif

  pixel_tagger #(
    .IMG_W(4),
    .IMG_H(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
`ifdef TAGGER_ERR_CNT_EN
    ,
    .err_cnt(err_cnt),
    .short_frame(short_frame)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [34:0] obs,
                       input logic [34:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push expectation, check after edge.
  task automatic step(input bit r, input bit s,
                      input bit v, input logic [11:0] p,
                      input bit acc,
                      input logic [10:0] ex,
                      input logic [10:0] ey,
                      input bit fd, input bit bz);
    logic [34:0] e;
    @(negedge clk);
    rst_n         = r;
    bus.sof       = s;
    bus.pix_valid = v;
    bus.pix       = p;
    if (!r) begin
      held = '0;
      sb.push_back(35'h0);
    end else if (acc) begin
      held = {ey, ex, p};
      sb.push_back({1'b1, ey, ex, p});
    end else begin
      sb.push_back({1'b0, held});
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("data_out", bus.data_out, e);
    check("frame_done", 35'(bus.frame_done), 35'(fd));
    check("busy", 35'(bus.busy), 35'(bz));
  endtask

  initial begin
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix       = '0;
    // reset held for 4 cycles, then released
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // full frame of 8 pixels
    step(1, 1, 1, 100, 1, 0, 0, 0, 1);
    step(1, 0, 1, 200, 1, 1, 0, 0, 1);
    step(1, 0, 1, 300, 1, 2, 0, 0, 1);
    step(1, 0, 1, 400, 1, 3, 0, 0, 1);
    step(1, 0, 1, 500, 1, 0, 1, 0, 1);
    step(1, 0, 1, 600, 1, 1, 1, 0, 1);
    step(1, 0, 1, 700, 1, 2, 1, 0, 1);
    step(1, 0, 1, 800, 1, 3, 1, 0, 0);
    step(1, 0, 1, 999, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // pixel without sof in IDLE is dropped
    step(1, 0, 1, 500, 0, 0, 0, 0, 0);

    // gapped stream
    step(1, 1, 1, 100, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 200, 1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 300, 1, 2, 0, 0, 1);

    // sof mid-frame aborts and restarts at (0,0)
    step(1, 1, 1, 11, 1, 0, 0, 0, 1);
    step(1, 0, 1, 12, 1, 1, 0, 0, 1);
    step(1, 0, 1, 13, 1, 2, 0, 0, 1);
    step(1, 0, 1, 14, 1, 3, 0, 0, 1);
    step(1, 0, 1, 15, 1, 0, 1, 0, 1);
    step(1, 0, 1, 16, 1, 1, 1, 0, 1);
    step(1, 0, 1, 17, 1, 2, 1, 0, 1);
    step(1, 0, 1, 18, 1, 3, 1, 0, 0);

    // back-to-back frame: sof during DONE
    step(1, 1, 1, 21, 1, 0, 0, 1, 1);
    step(1, 0, 1, 22, 1, 1, 0, 0, 1);
    step(1, 0, 1, 23, 1, 2, 0, 0, 1);
    step(1, 0, 1, 24, 1, 3, 0, 0, 1);
    step(1, 0, 1, 25, 1, 0, 1, 0, 1);

`ifdef TAGGER_ERR_CNT_EN
    check("err_cnt", 35'(err_cnt), 35'd1);
    check("short_frame", 35'(short_frame), 35'd1);
`endif

    // reset mid-frame discards everything
    step(0, 0, 1, 26, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef TAGGER_ERR_CNT_EN
    check("err_cnt_rst", 35'(err_cnt), 35'd0);
    check("short_rst", 35'(short_frame), 35'd0);
`endif

    // first sof after reset starts at (0,0)
    step(1, 1, 1, 31, 1, 0, 0, 0, 1);
    step(1, 0, 1, 32, 1, 1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
